prime_uart_tx: RTL

- Downstream consumer of the primogen result on the icestick board.
- Accepts each new prime through a valid/ready handshake and converts it to unsigned decimal ASCII, most significant digit first.
- Appends CR LF to each number and transmits it over a UART TX line to the FTDI serial port.
- Sits beside the LED display logic; the board top asserts valid for one cycle whenever it latches a new prime.

---
 rtl/prime_uart_pkg.sv | 31 +++
 rtl/uart_tx.sv | 87 ++++++++
 rtl/prime_uart_tx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/prime_uart_pkg.sv
// prime_uart_pkg
// Shared definitions for the prime-to-UART decimal printer:
//   - ASCII constants for the digit base and the line terminator
//   - NDIG(w): number of decimal digits needed for the largest w-bit value
//   - state_t: top-level sequencing states
package prime_uart_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SEND = 2'd2
  } state_t;

  // Digits in (2**w - 1): 5 for w=16, 10 for w=32.
  function automatic int NDIG(input int w);
    longint unsigned maxVal;
    int n;
    maxVal = (64'd1 << w) - 64'd1;
    n = 1;
    while (maxVal >= 64'd10) begin
      maxVal = maxVal / 64'd10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx
// Byte serializer, LSB first, idle-high line.
// Frame: start(0), 8 data bits, [even parity], stop(1); every bit lasts
// BIT_CYC clocks.
// Build option: PRIME_UART_PARITY_EN selects 8E1 frames; otherwise 8N1.
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset (forces tx high)
//   start    load tx_byte when not busy
//   tx_byte  character to send
//   busy     low when a new character may be loaded this cycle
//   tx       registered serial output
module uart_tx #(
  parameter int BIT_CYC = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       busy,
  output logic       tx
);

`ifdef PRIME_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Shift register holds everything after the start bit.
  localparam int SW  = NBITS - 1;
  localparam int BCW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int BIW = $clog2(NBITS);

  logic [SW-1:0]  w_frame;
  logic [SW-1:0]  r_shift;
  logic [BCW-1:0] r_baud;
  logic [BIW-1:0] r_bitIdx;
  logic           r_busy;
  logic           r_tx;
  logic           w_bitEnd;
  logic           w_lastCycle;

`ifdef PRIME_UART_PARITY_EN
  assign w_frame = {1'b1, ^tx_byte, tx_byte};
`else
  assign w_frame = {1'b1, tx_byte};
`endif

  assign w_bitEnd    = (r_baud == BCW'(BIT_CYC - 1));
  assign w_lastCycle = r_busy && w_bitEnd && (r_bitIdx == BIW'(NBITS - 1));

  // Advertising idle during the final stop-bit cycle lets the next character
  // load on the very edge the stop bit ends, so frames run back-to-back.
  assign busy = r_busy && !w_lastCycle;
  assign tx   = r_tx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift  <= '0;
      r_baud   <= '0;
      r_bitIdx <= '0;
      r_busy   <= 1'b0;
      r_tx     <= 1'b1;
    end else if (start && !busy) begin
      r_shift  <= w_frame;
      r_baud   <= '0;
      r_bitIdx <= '0;
      r_busy   <= 1'b1;
      r_tx     <= 1'b0;
    end else if (r_busy) begin
      if (w_bitEnd) begin
        r_baud <= '0;
        if (r_bitIdx == BIW'(NBITS - 1)) begin
          r_busy <= 1'b0;
          r_tx   <= 1'b1;
        end else begin
          r_tx     <= r_shift[0];
          r_shift  <= {1'b1, r_shift[SW-1:1]};
          r_bitIdx <= r_bitIdx + 1'b1;
        end
      end else begin
        r_baud <= r_baud + 1'b1;
      end
    end
  end

endmodule

// File: rtl/prime_uart_tx.sv
// prime_uart_tx
// Accepts a binary value over valid/ready, converts it to unsigned decimal
// ASCII (most significant digit first) and sends it followed by CR LF.
// Build option: PRIME_UART_PARITY_EN (passed through to uart_tx) selects
// 8E1 framing; the default build is 8N1.
// Ports:
//   clk    system clock
//   rst    asynchronous active-high reset
//   valid  data holds a value to print
//   data   unsigned value, W = 1 << WIDTH_LOG bits
//   ready  idle and accepting data this cycle
//   tx     UART line to the FTDI bridge, idle high
module prime_uart_tx
  import prime_uart_pkg::*;
#(
  parameter int WIDTH_LOG = 4,
  parameter int CLK_HZ    = 12000000,
  parameter int BAUD      = 115200
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid,
  input  logic [(1<<WIDTH_LOG)-1:0] data,
  output logic                      ready,
  output logic                      tx
);

  localparam int W       = 1 << WIDTH_LOG;
  localparam int ND      = NDIG(W);
  localparam int CW      = $clog2(ND + 1);
  localparam int BIT_CYC = CLK_HZ / BAUD;

  state_t               r_state;
  state_t               w_nextState;
  logic                 r_ready;
  logic [W-1:0]         r_work;
  logic [3:0]           r_rem;
  logic [WIDTH_LOG-1:0] r_bitCnt;
  logic [3:0]           r_digits [ND];
  logic [CW-1:0]        r_digCnt;
  logic [1:0]           r_tail;

  logic                 w_xfer;
  logic [W:0]           w_trial;
  logic [W:0]           w_diff;
  logic                 w_qBit;
  logic [3:0]           w_remNext;
  logic [W-1:0]         w_workNext;
  logic                 w_digitDone;
  logic                 w_convDone;
  logic                 w_start;
  logic                 w_busy;
  logic [7:0]           w_char;

  assign w_xfer = valid && r_ready;
  assign ready  = r_ready;

  // One restoring-division step: bring in the next dividend bit and try to
  // subtract 10. The trial is at most 19, so a non-negative result fits in
  // 4 bits and a borrow sets every bit from 4 upward.
  assign w_trial     = {{(W-4){1'b0}}, r_rem, r_work[W-1]};
  assign w_diff      = w_trial - (W+1)'(10);
  assign w_qBit      = ~|w_diff[W:4];
  assign w_remNext   = w_qBit ? w_diff[3:0] : w_trial[3:0];
  assign w_workNext  = {r_work[W-2:0], w_qBit};
  assign w_digitDone = (r_state == CONV) && (r_bitCnt == '1);
  assign w_convDone  = w_digitDone && (w_workNext == '0);

  // r_tail: 0 = CR next, 1 = LF next, 2 = every character has been loaded.
  assign w_start = (r_state == SEND) && !w_busy && (r_tail != 2'd2);

  always_comb begin
    w_char = ASCII_LF;
    if (r_digCnt != '0) begin
      w_char = ASCII_ZERO + {4'h0, r_digits[0]};
    end else if (r_tail == 2'd0) begin
      w_char = ASCII_CR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_xfer) w_nextState = CONV;
      CONV:    if (w_convDone) w_nextState = SEND;
      SEND:    if ((r_tail == 2'd2) && !w_busy) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Digits are pushed at index 0 as they emerge least significant first, so
  // after conversion index 0 holds the most significant digit; sending pops
  // from index 0 and shifts the rest down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready  <= 1'b0;
      r_work   <= '0;
      r_rem    <= '0;
      r_bitCnt <= '0;
      r_digCnt <= '0;
      r_tail   <= '0;
      for (int i = 0; i < ND; i++) r_digits[i] <= '0;
    end else begin
      r_ready <= (w_nextState == IDLE);
      unique case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_work   <= data;
            r_rem    <= '0;
            r_bitCnt <= '0;
            r_digCnt <= '0;
            r_tail   <= '0;
          end
        end
        CONV: begin
          r_work   <= w_workNext;
          r_bitCnt <= r_bitCnt + 1'b1;
          if (w_digitDone) begin
            r_rem <= '0;
            for (int i = ND - 1; i > 0; i--) r_digits[i] <= r_digits[i-1];
            r_digits[0] <= w_remNext;
            r_digCnt    <= r_digCnt + 1'b1;
          end else begin
            r_rem <= w_remNext;
          end
        end
        SEND: begin
          if (w_start) begin
            if (r_digCnt != '0) begin
              for (int i = 0; i < ND - 1; i++) r_digits[i] <= r_digits[i+1];
              r_digits[ND-1] <= '0;
              r_digCnt       <= r_digCnt - 1'b1;
            end else begin
              r_tail <= r_tail + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  uart_tx #(
    .BIT_CYC (BIT_CYC)
  ) u_uartTx (
    .clk     (clk),
    .rst     (rst),
    .start   (w_start),
    .tx_byte (w_char),
    .busy    (w_busy),
    .tx      (tx)
  );

endmodule
